// File: rtl/multi_digit_scan_disp.sv
// Multiplexed multi-digit seven-segment scanner with frame-synchronous updates,
// leading-zero blanking, per-digit blink and PWM brightness control.
module multi_digit_scan_disp #(
  parameter int DIGITS  = 8,
  parameter int DIV_W   = 16,
  parameter int PWM_W   = 4,
  parameter int BLINK_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   hex_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic [PWM_W-1:0]      bright,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            sseg,
  output logic                  frame_tick,
  output logic                  pending
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BLINK_W-1:0]  frame_q, frame_d;
  logic [4*DIGITS-1:0] shadowHex_q, shadowHex_d;
  logic [DIGITS-1:0]   shadowDp_q, shadowDp_d;
  logic [4*DIGITS-1:0] activeHex_q, activeHex_d;
  logic [DIGITS-1:0]   activeDp_q, activeDp_d;
  logic                pending_q, pending_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          sseg_q, sseg_d;

  logic                slotEnd;
  logic                frameTick;
  logic [DIGITS-1:0]   lzBlank;
  logic [3:0]          curHex;
  logic                curDp;
  logic                curBlink;
  logic                curLz;
  logic                pwmOn;
  logic                blinkOff;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    g = 7'h7F;
    case (v)
      4'h0: g = 7'h01;
      4'h1: g = 7'h4F;
      4'h2: g = 7'h12;
      4'h3: g = 7'h06;
      4'h4: g = 7'h4C;
      4'h5: g = 7'h24;
      4'h6: g = 7'h20;
      4'h7: g = 7'h0F;
      4'h8: g = 7'h00;
      4'h9: g = 7'h04;
      4'hA: g = 7'h08;
      4'hB: g = 7'h60;
      4'hC: g = 7'h31;
      4'hD: g = 7'h42;
      4'hE: g = 7'h30;
      4'hF: g = 7'h38;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // The frame boundary is the last cycle of the last digit slot; the commit
  // happens on that edge so the whole next frame sees one consistent value.
  assign slotEnd   = &presc_q;
  assign frameTick = slotEnd && (idx_q == LAST_IDX);

  always_comb begin
    presc_d     = presc_q + 1'b1;
    idx_d       = idx_q;
    frame_d     = frame_q;
    shadowHex_d = shadowHex_q;
    shadowDp_d  = shadowDp_q;
    activeHex_d = activeHex_q;
    activeDp_d  = activeDp_q;
    pending_d   = pending_q;

    if (slotEnd) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
    if (frameTick) begin
      frame_d = frame_q + 1'b1;
    end

    // A load landing on the commit edge goes straight to the display.
    if (load && frameTick) begin
      shadowHex_d = hex_in;
      shadowDp_d  = dp_in;
      activeHex_d = hex_in;
      activeDp_d  = dp_in;
      pending_d   = 1'b0;
    end else if (load) begin
      shadowHex_d = hex_in;
      shadowDp_d  = dp_in;
      pending_d   = 1'b1;
    end else if (frameTick && pending_q) begin
      activeHex_d = shadowHex_q;
      activeDp_d  = shadowDp_q;
      pending_d   = 1'b0;
    end
  end

  // Scan from the most significant digit down; a digit is a leading zero while
  // every digit above it (and itself) is zero. Digit 0 always stays visible.
  always_comb begin
    logic zeroRun;
    lzBlank = '0;
    zeroRun = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zeroRun = zeroRun && (activeHex_q[4*i +: 4] == 4'h0);
      if (i != 0) begin
        lzBlank[i] = blank_lz && zeroRun;
      end
    end
  end

  always_comb begin
    curHex   = 4'h0;
    curDp    = 1'b0;
    curBlink = 1'b0;
    curLz    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        curHex   = activeHex_q[4*i +: 4];
        curDp    = activeDp_q[i];
        curBlink = blink_mask[i];
        curLz    = lzBlank[i];
      end
    end
  end

  assign pwmOn    = (presc_q[DIV_W-1 -: PWM_W] <= bright);
  assign blinkOff = curBlink && frame_q[BLINK_W-1];

  always_comb begin
    an_d   = '1;
    sseg_d = 8'hFF;
    if (pwmOn && !curLz && !blinkOff) begin
      an_d   = ~(DIGITS'(1) << idx_q);
      sseg_d = {~curDp, glyph(curHex)};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q     <= '0;
      idx_q       <= '0;
      frame_q     <= '0;
      shadowHex_q <= '0;
      shadowDp_q  <= '0;
      activeHex_q <= '0;
      activeDp_q  <= '0;
      pending_q   <= 1'b0;
      an_q        <= '1;
      sseg_q      <= 8'hFF;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      shadowHex_q <= shadowHex_d;
      shadowDp_q  <= shadowDp_d;
      activeHex_q <= activeHex_d;
      activeDp_q  <= activeDp_d;
      pending_q   <= pending_d;
      an_q        <= an_d;
      sseg_q      <= sseg_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = frameTick;
  assign pending    = pending_q;

endmodule

// File: tb/tb_multi_digit_scan_disp.sv
// Directed bench for the scanner at DIGITS=4, DIV_W=4, PWM_W=2, BLINK_W=2:
// one slot is 16 cycles, one frame is 64 cycles.
module tb_multi_digit_scan_disp;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] hex_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  blink_mask;
  logic [1:0]  bright;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_tick;
  logic        pending;

  int checks = 0;
  int errors = 0;
  int cyc;

  typedef struct packed {
    logic [15:0] hex;
    logic [3:0]  dp;
    logic        blz;
    logic [1:0]  bright;
    logic [1:0]  digit;
    logic [3:0]  presc;
    logic [3:0]  expAn;
    logic [7:0]  expSseg;
  } vec_t;

  vec_t vecs[29];

  multi_digit_scan_disp #(
    .DIGITS(4), .DIV_W(4), .PWM_W(2), .BLINK_W(2)
  ) dut (
    .clk(clk), .reset(reset), .hex_in(hex_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .blink_mask(blink_mask), .bright(bright),
    .an(an), .sseg(sseg), .frame_tick(frame_tick), .pending(pending)
  );

  always #5 clk = ~clk;

  // Cycle number since reset release; cycle 0 is the interval before the first edge.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic [15:0] hex, input logic [3:0] dp, input logic blz,
                              input logic [1:0] br, input logic [1:0] dg, input logic [3:0] ps,
                              input logic [3:0] ea, input logic [7:0] es);
    vec_t v;
    v = {hex, dp, blz, br, dg, ps, ea, es};
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic gotoCycle(input int t);
    if (cyc > t) begin
      checks++;
      errors++;
      $display("[TB] FAIL schedule: at cycle %0d, wanted cycle %0d", cyc, t);
    end
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Load a vector early in a frame, then look at one slot of the following frame.
  task automatic applyStimulus(input int n, input vec_t v);
    int f;
    f = cyc / 64 + 1;
    gotoCycle(64*f + 8);
    hex_in   = v.hex;
    dp_in    = v.dp;
    blank_lz = v.blz;
    bright   = v.bright;
    load     = 1'b1;
    gotoCycle(64*f + 9);
    load = 1'b0;
    checkOutput($sformatf("vec%0d_pending", n), {31'd0, pending}, 32'd1);
    gotoCycle(64*(f+1) + 16*int'(v.digit) + int'(v.presc) + 1);
    checkOutput($sformatf("vec%0d_an", n), {28'd0, an}, {28'd0, v.expAn});
    checkOutput($sformatf("vec%0d_sseg", n), {24'd0, sseg}, {24'd0, v.expSseg});
  endtask

  initial begin
    int f;
    int cnt;
    vecs[0]  = mk(16'h1234, 4'b0010, 1'b0, 2'd3, 2'd0, 4'd5, 4'b1110, 8'hCC);
    vecs[1]  = mk(16'h1234, 4'b0010, 1'b0, 2'd3, 2'd1, 4'd5, 4'b1101, 8'h06);
    vecs[2]  = mk(16'h1234, 4'b0010, 1'b0, 2'd3, 2'd2, 4'd5, 4'b1011, 8'h92);
    vecs[3]  = mk(16'h1234, 4'b0010, 1'b0, 2'd3, 2'd3, 4'd5, 4'b0111, 8'hCF);
    vecs[4]  = mk(16'h0005, 4'b0000, 1'b1, 2'd3, 2'd0, 4'd5, 4'b1110, 8'hA4);
    vecs[5]  = mk(16'h0005, 4'b0000, 1'b1, 2'd3, 2'd1, 4'd5, 4'b1111, 8'hFF);
    vecs[6]  = mk(16'h0005, 4'b0000, 1'b1, 2'd3, 2'd3, 4'd5, 4'b1111, 8'hFF);
    vecs[7]  = mk(16'h0000, 4'b0000, 1'b1, 2'd3, 2'd0, 4'd5, 4'b1110, 8'h81);
    vecs[8]  = mk(16'h0000, 4'b0000, 1'b1, 2'd3, 2'd2, 4'd5, 4'b1111, 8'hFF);
    vecs[9]  = mk(16'h0000, 4'b0000, 1'b0, 2'd3, 2'd2, 4'd5, 4'b1011, 8'h81);
    vecs[10] = mk(16'h0F0A, 4'b0000, 1'b1, 2'd3, 2'd3, 4'd5, 4'b1111, 8'hFF);
    vecs[11] = mk(16'h0F0A, 4'b0000, 1'b1, 2'd3, 2'd1, 4'd5, 4'b1101, 8'h81);
    vecs[12] = mk(16'h0F0A, 4'b0000, 1'b1, 2'd3, 2'd0, 4'd5, 4'b1110, 8'h88);
    vecs[13] = mk(16'h0F0A, 4'b0000, 1'b1, 2'd3, 2'd2, 4'd5, 4'b1011, 8'hB8);
    vecs[14] = mk(16'h89CB, 4'b1000, 1'b0, 2'd3, 2'd3, 4'd9, 4'b0111, 8'h00);
    vecs[15] = mk(16'h89CB, 4'b1000, 1'b0, 2'd3, 2'd0, 4'd9, 4'b1110, 8'hE0);
    vecs[16] = mk(16'h89CB, 4'b1000, 1'b0, 2'd3, 2'd1, 4'd0, 4'b1101, 8'hB1);
    vecs[17] = mk(16'h89CB, 4'b1000, 1'b0, 2'd3, 2'd2, 4'd14, 4'b1011, 8'h84);
    vecs[18] = mk(16'h67DE, 4'b0000, 1'b0, 2'd3, 2'd0, 4'd3, 4'b1110, 8'hB0);
    vecs[19] = mk(16'h67DE, 4'b0000, 1'b0, 2'd3, 2'd1, 4'd3, 4'b1101, 8'hC2);
    vecs[20] = mk(16'h67DE, 4'b0000, 1'b0, 2'd3, 2'd2, 4'd3, 4'b1011, 8'h8F);
    vecs[21] = mk(16'h67DE, 4'b0000, 1'b0, 2'd3, 2'd3, 4'd3, 4'b0111, 8'hA0);
    vecs[22] = mk(16'h1234, 4'b0010, 1'b0, 2'd0, 2'd0, 4'd2, 4'b1110, 8'hCC);
    vecs[23] = mk(16'h1234, 4'b0010, 1'b0, 2'd0, 2'd0, 4'd4, 4'b1111, 8'hFF);
    vecs[24] = mk(16'h1234, 4'b0010, 1'b0, 2'd1, 2'd0, 4'd7, 4'b1110, 8'hCC);
    vecs[25] = mk(16'h1234, 4'b0010, 1'b0, 2'd1, 2'd0, 4'd8, 4'b1111, 8'hFF);
    vecs[26] = mk(16'h1234, 4'b0010, 1'b0, 2'd2, 2'd0, 4'd11, 4'b1110, 8'hCC);
    vecs[27] = mk(16'h1234, 4'b0010, 1'b0, 2'd2, 2'd0, 4'd12, 4'b1111, 8'hFF);
    vecs[28] = mk(16'h1234, 4'b0010, 1'b0, 2'd0, 2'd1, 4'd3, 4'b1101, 8'h06);

    reset      = 1'b1;
    hex_in     = 16'h0;
    dp_in      = 4'h0;
    load       = 1'b0;
    blank_lz   = 1'b0;
    blink_mask = 4'h0;
    bright     = 2'd3;

    // Reset values, then first slot and frame_tick placement.
    #12;
    checkOutput("rst_an", {28'd0, an}, 32'hF);
    checkOutput("rst_sseg", {24'd0, sseg}, 32'hFF);
    checkOutput("rst_pending", {31'd0, pending}, 32'd0);
    checkOutput("rst_tick", {31'd0, frame_tick}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("c0_an", {28'd0, an}, 32'hF);
    checkOutput("c0_sseg", {24'd0, sseg}, 32'hFF);
    gotoCycle(1);
    checkOutput("c1_an", {28'd0, an}, 32'hE);
    checkOutput("c1_sseg", {24'd0, sseg}, 32'h81);
    gotoCycle(62);
    checkOutput("c62_tick", {31'd0, frame_tick}, 32'd0);
    gotoCycle(63);
    checkOutput("c63_tick", {31'd0, frame_tick}, 32'd1);
    gotoCycle(64);
    checkOutput("c64_tick", {31'd0, frame_tick}, 32'd0);
    gotoCycle(127);
    checkOutput("c127_tick", {31'd0, frame_tick}, 32'd1);

    for (int i = 0; i < 29; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Mid-frame load: old value stays up until the frame boundary.
    bright   = 2'd3;
    blank_lz = 1'b0;
    f = cyc / 64 + 1;
    gotoCycle(64*f + 20);
    hex_in = 16'h0005;
    dp_in  = 4'b0000;
    load   = 1'b1;
    gotoCycle(64*f + 21);
    load = 1'b0;
    checkOutput("mid_pending", {31'd0, pending}, 32'd1);
    gotoCycle(64*f + 54);
    checkOutput("mid_old_an", {28'd0, an}, 32'h7);
    checkOutput("mid_old_sseg", {24'd0, sseg}, 32'hCF);
    gotoCycle(64*f + 63);
    checkOutput("mid_tick", {31'd0, frame_tick}, 32'd1);
    checkOutput("mid_pending_at_tick", {31'd0, pending}, 32'd1);
    gotoCycle(64*(f+1));
    checkOutput("mid_pending_cleared", {31'd0, pending}, 32'd0);
    gotoCycle(64*(f+1) + 6);
    checkOutput("mid_new_d0", {24'd0, sseg}, 32'hA4);
    gotoCycle(64*(f+1) + 54);
    checkOutput("mid_new_d3_an", {28'd0, an}, 32'h7);
    checkOutput("mid_new_d3_sseg", {24'd0, sseg}, 32'h81);

    // Load exactly on the frame boundary bypasses into the display.
    f = cyc / 64 + 1;
    gotoCycle(64*f + 63);
    checkOutput("byp_tick", {31'd0, frame_tick}, 32'd1);
    checkOutput("byp_pending_before", {31'd0, pending}, 32'd0);
    hex_in = 16'h00A7;
    dp_in  = 4'b0001;
    load   = 1'b1;
    gotoCycle(64*(f+1));
    load = 1'b0;
    checkOutput("byp_pending", {31'd0, pending}, 32'd0);
    gotoCycle(64*(f+1) + 1);
    checkOutput("byp_d0_an", {28'd0, an}, 32'hE);
    checkOutput("byp_d0_sseg", {24'd0, sseg}, 32'h0F);
    gotoCycle(64*(f+1) + 17);
    checkOutput("byp_d1_an", {28'd0, an}, 32'hD);
    checkOutput("byp_d1_sseg", {24'd0, sseg}, 32'h88);
    gotoCycle(64*(f+1) + 63);
    checkOutput("byp_pending_late", {31'd0, pending}, 32'd0);

    // Blink: digit 0 dark in frames 2 and 3 of every 4 since reset.
    blink_mask = 4'b0001;
    f = cyc / 64 + 1;
    for (int k = 0; k < 4; k++) begin
      gotoCycle(64*(f+k) + 6);
      if (((f + k) % 4) >= 2) begin
        checkOutput($sformatf("blink_f%0d_d0_an", f+k), {28'd0, an}, 32'hF);
        checkOutput($sformatf("blink_f%0d_d0_sseg", f+k), {24'd0, sseg}, 32'hFF);
      end else begin
        checkOutput($sformatf("blink_f%0d_d0_an", f+k), {28'd0, an}, 32'hE);
        checkOutput($sformatf("blink_f%0d_d0_sseg", f+k), {24'd0, sseg}, 32'h0F);
      end
      gotoCycle(64*(f+k) + 22);
      checkOutput($sformatf("blink_f%0d_d1_sseg", f+k), {24'd0, sseg}, 32'h88);
    end
    blink_mask = 4'b0000;

    // PWM duty over one digit-0 slot, plus one-hot anode check.
    bright = 2'd0;
    f = cyc / 64 + 1;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      gotoCycle(64*f + 1 + i);
      if (an[0] == 1'b0) cnt++;
      checkOutput("pwm0_onehot", {31'd0, ($countones(~an) <= 1)}, 32'd1);
    end
    checkOutput("pwm_bright0_duty", cnt, 32'd4);
    bright = 2'd3;
    f = cyc / 64 + 1;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      gotoCycle(64*f + 1 + i);
      if (an[0] == 1'b0) cnt++;
    end
    checkOutput("pwm_bright3_duty", cnt, 32'd16);

    // Reset mid-slot with a pending load discards the shadow data.
    f = cyc / 64 + 1;
    gotoCycle(64*f + 10);
    hex_in = 16'hFFFF;
    dp_in  = 4'hF;
    load   = 1'b1;
    gotoCycle(64*f + 11);
    load = 1'b0;
    checkOutput("rst2_pending_before", {31'd0, pending}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst2_an", {28'd0, an}, 32'hF);
    checkOutput("rst2_sseg", {24'd0, sseg}, 32'hFF);
    checkOutput("rst2_pending", {31'd0, pending}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    gotoCycle(1);
    checkOutput("rst2_c1_an", {28'd0, an}, 32'hE);
    checkOutput("rst2_c1_sseg", {24'd0, sseg}, 32'h81);
    gotoCycle(64 + 6);
    checkOutput("rst2_next_frame_sseg", {24'd0, sseg}, 32'h81);
    checkOutput("rst2_next_frame_pending", {31'd0, pending}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
